// File: rtl/frog_game_ctrl_pkg.sv
// rtl/frog_game_ctrl_pkg.sv - shared state encodings and screen geometry for the frog game controller
package frog_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [9:0] DEF_START_X = 10'd304;
  localparam logic [9:0] DEF_START_Y = 10'd448;
  localparam logic [9:0] DEF_STEP    = 10'd32;
  localparam logic [9:0] DEF_MAX_X   = 10'd608;

  // Priority encoder for simultaneous presses: up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down, input logic left);
    if (up)        return DIR_UP;
    else if (down) return DIR_DOWN;
    else if (left) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// rtl/frog_game_ctrl_if.sv - button/collision inputs and game-state outputs of the frog game controller
interface frog_game_ctrl_if;
  import frog_game_ctrl_pkg::*;

  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       collision;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] score;
  logic [3:0] car_speed;
  logic       freeze;
  logic [2:0] state;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, collision,
    input  player_x, player_y, lives, level, score, car_speed, freeze, state
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, collision,
    output player_x, player_y, lives, level, score, car_speed, freeze, state
  );

endinterface

// File: rtl/frog_game_ctrl.sv
// rtl/frog_game_ctrl.sv - per-frame game state machine: player movement, lives, level, score, car speed
module frog_game_ctrl
  import frog_game_ctrl_pkg::*;
#(
  parameter logic [9:0] START_X      = DEF_START_X,
  parameter logic [9:0] START_Y      = DEF_START_Y,
  parameter logic [9:0] STEP         = DEF_STEP,
  parameter logic [9:0] MAX_X        = DEF_MAX_X,
  parameter int         LIVES        = 3,
  parameter int         PAUSE_FRAMES = 60,
  parameter int         MAX_LEVEL    = 7
) (
  input  logic             CLK,
  input  logic             RST,
  frog_game_ctrl_if.slave  bus
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [5:0] PAUSE_LOAD = 6'(PAUSE_FRAMES - 1);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

  state_t     state_q;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] score;
  logic [3:0] car_speed;
  logic       freeze;
  logic       pend_valid;
  dir_t       pend_dir;
  logic       hit_sticky;
  logic [5:0] pause_cnt;

  logic       press_any;
  dir_t       press_dir;
  logic       move_valid;
  dir_t       move_dir;
  logic       hit_now;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [2:0] level_next;
  logic [7:0] score_next;

  // A press or collision in the tick cycle itself counts toward that tick.
  always_comb begin
    press_any  = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    press_dir  = pick_dir(bus.btn_up, bus.btn_down, bus.btn_left);
    move_valid = pend_valid | press_any;
    move_dir   = pend_valid ? pend_dir : press_dir;
    hit_now    = hit_sticky | bus.collision;
  end

  always_comb begin
    next_x = player_x;
    next_y = player_y;
    if (move_valid) begin
      case (move_dir)
        DIR_UP:    if (player_y >= STEP) next_y = player_y - STEP;
        DIR_DOWN:  if (player_y != START_Y) next_y = player_y + STEP;
        DIR_LEFT:  if (player_x >= STEP) next_x = player_x - STEP;
        DIR_RIGHT: if ({1'b0, player_x} + {1'b0, STEP} <= {1'b0, MAX_X}) next_x = player_x + STEP;
        default:   ;
      endcase
    end
  end

  always_comb begin
    level_next = (level >= LEVEL_MAX) ? level : level + 3'd1;
    score_next = (score == 8'hFF) ? score : score + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      player_x   <= START_X;
      player_y   <= START_Y;
      lives      <= LIVES_INIT;
      level      <= 3'd0;
      score      <= 8'd0;
      car_speed  <= 4'd1;
      freeze     <= 1'b1;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_UP;
      hit_sticky <= 1'b0;
      pause_cnt  <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.btn_start) begin
            state_q <= ST_PLAY;
            freeze  <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (bus.frame_tick) begin
            pend_valid <= 1'b0;
            hit_sticky <= 1'b0;
            if (hit_now) begin
              lives     <= lives - 2'd1;
              state_q   <= ST_HIT;
              freeze    <= 1'b1;
              pause_cnt <= PAUSE_LOAD;
            end else begin
              player_x <= next_x;
              player_y <= next_y;
              if (next_y == 10'd0) begin
                state_q   <= ST_WIN;
                freeze    <= 1'b1;
                pause_cnt <= PAUSE_LOAD;
              end
            end
          end else begin
            if (!pend_valid && press_any) begin
              pend_valid <= 1'b1;
              pend_dir   <= press_dir;
            end
            if (bus.collision) hit_sticky <= 1'b1;
          end
        end

        ST_HIT: begin
          if (bus.frame_tick) begin
            if (pause_cnt != 6'd0) begin
              pause_cnt <= pause_cnt - 6'd1;
            end else if (lives == 2'd0) begin
              state_q <= ST_OVER;
            end else begin
              player_x <= START_X;
              player_y <= START_Y;
              state_q  <= ST_PLAY;
              freeze   <= 1'b0;
            end
          end
        end

        ST_WIN: begin
          if (bus.frame_tick) begin
            if (pause_cnt != 6'd0) begin
              pause_cnt <= pause_cnt - 6'd1;
            end else begin
              level     <= level_next;
              car_speed <= {1'b0, level_next} + 4'd1;
              score     <= score_next;
              player_x  <= START_X;
              player_y  <= START_Y;
              state_q   <= ST_PLAY;
              freeze    <= 1'b0;
            end
          end
        end

        ST_OVER: begin
          if (bus.btn_start) begin
            state_q    <= ST_IDLE;
            player_x   <= START_X;
            player_y   <= START_Y;
            lives      <= LIVES_INIT;
            level      <= 3'd0;
            score      <= 8'd0;
            car_speed  <= 4'd1;
            freeze     <= 1'b1;
            pend_valid <= 1'b0;
            hit_sticky <= 1'b0;
            pause_cnt  <= 6'd0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          freeze  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.player_x  = player_x;
  assign bus.player_y  = player_y;
  assign bus.lives     = lives;
  assign bus.level     = level;
  assign bus.score     = score;
  assign bus.car_speed = car_speed;
  assign bus.freeze    = freeze;
  assign bus.state     = state_q;

endmodule

// File: doc/frog_game_ctrl.md
# frog_game_ctrl

Game-state controller for the frog-crossing game. It owns the player position, lives, level, score and car-speed setting, and advances them once per video frame from debounced button pulses and a collision flag. Its outputs drive the player position inputs of the colour/sprite generation stage and the speed input of the car movement logic. A five-state FSM sequences idle, play, hit, win and game-over phases.

## Interface
- START_X, 304: player reset column (pixels)
- START_Y, 448: player reset row (pixels)
- STEP, 32: move distance per accepted button press (one tile)
- MAX_X, 608: largest legal player_x
- LIVES, 3: lives at game start (1..3)
- PAUSE_FRAMES, 60: frames spent in HIT and WIN
- MAX_LEVEL, 7: level saturation value

- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced one-cycle press pulses
- btn_start  in  1  debounced one-cycle pulse
- collision  in  1  level signal, high while frog pixels overlap car pixels
- player_x, player_y  out  10 each  player top-left position
- lives  out  2  remaining lives
- level  out  3  current level
- score  out  8  completed crossings, saturating
- car_speed  out  4  level + 1, pixels per frame for car logic
- freeze  out  1  high when cars must not move
- state  out  3  FSM state encoding

## Operation
- One clock and one reset only. Synchronous, active-high reset: state=IDLE, player_x=START_X, player_y=START_Y, lives=LIVES, level=0, score=0, car_speed=1, freeze=1. All pending and sticky flags and the pause counter are 0.
- States: IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4.
- IDLE: freeze=1. Position, lives, level and score are held at their reset values. btn_start moves to PLAY.
- PLAY: freeze=0.
  - Pending move: the first direction pulse latches. Later pulses in the same frame are ignored. If two directions arrive in the same cycle, priority is up > down > left > right. A press coincident with frame_tick is included in that tick.
  - Sticky hit flag: set by collision while in PLAY.
  - At frame_tick, the sticky hit has priority over movement:
    - Hit set: lives decrements, the move is discarded, and the state goes to HIT.
    - Otherwise, the pending move is applied with clamping:
      - left: ignored if player_x < STEP
      - right: ignored if player_x + STEP > MAX_X
      - down: ignored if player_y == START_Y
      - up: player_y - STEP. A result of 0 goes to WIN.
    - Pending and sticky flags clear at every frame_tick.
- HIT: freeze=1. Pause counter loads PAUSE_FRAMES-1 on entry and decrements per frame_tick. At the tick where the count is 0:
  - lives == 0: go to OVER.
  - otherwise: reset position to START_X/START_Y and go to PLAY.
- WIN: same pause as HIT. At expiry:
  - level = min(level+1, MAX_LEVEL)
  - score = min(score+1, 255)
  - car_speed = new level + 1
  - position resets to start, state goes to PLAY.
- OVER: freeze=1, outputs held. btn_start goes to IDLE, which restores the reset values.
- Buttons and collision are ignored outside PLAY, except btn_start in IDLE and OVER.

## Timing
- All outputs are registered. Updates are visible the cycle after the causing frame_tick or btn_start edge.
- Movement latency: press to position change is at most one frame, plus 1 cycle.
- HIT and WIN last exactly PAUSE_FRAMES frame_ticks, counted from the tick after entry.
- car_speed updates in the same cycle as level.
- RST asserted mid-frame or mid-pause overrides everything on the next edge. No partial state survives.
- frame_tick in the same cycle as the state-entry edge is not counted toward the pause.

## Structure
- State encodings and the default screen geometry (START_X, START_Y, STEP, MAX_X) go in the shared constants.v, alongside the existing sprite and lane constants.
- The pause counter is a 6-bit down-counter, kept inline. No sub-module is required.

## Test plan
- Reset, btn_start, then 3 × btn_up on separate frames -> player_y = 448, 416, 384, 352; state=1; freeze=0.
- player_x=0 with btn_left, and player_x=608 with btn_right -> position unchanged.
- btn_up and btn_left in the same cycle -> only up applied; y decreases by 32, x unchanged.
- collision pulse plus btn_up in the same frame -> lives 3→2, y unchanged, state=2. After 60 ticks: state=1 at (304,448).
- Three hits -> lives=0, state=4 after the pause. btn_start -> state=0 with lives=3.
- 14 ups reach y=0 -> state=3. After 60 ticks: level=1, car_speed=2, score=1, position at start. Repeated wins saturate level at 7.
